// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-side signals of the load/store access sequencer.
// The core (or bench) drives through master; the sequencer uses slave.
interface mem_access_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic [63:0] rsp_rdata;
   logic        rsp_misalign;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_wr;
   logic [63:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_misalign, mem_addr, mem_wdata, mem_wr
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_misalign, mem_addr, mem_wdata, mem_wr
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for a 64-bit data memory: aligned loads with extension,
// read-modify-write for sub-doubleword stores, misaligned requests rejected.
module mem_access_ctrl #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic            Clk,
   input  logic            Reset,
   mem_access_ctrl_if.slave bus
);
   localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             lat_we_q;
   logic             lat_uns_q;
   logic [1:0]       lat_size_q;
   logic [63:0]      lat_addr_q;
   logic [63:0]      lat_wdata_q;
   logic [63:0]      rd_buf_q;
   logic [63:0]      rsp_rdata_q;
   logic             rsp_mis_q;

   logic [63:0]      ld_data_d;
   logic [63:0]      merge_d;
   logic             req_mis_d;

   function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] a);
      case (sz)
         2'd0:    return 1'b0;
         2'd1:    return a[0];
         2'd2:    return a[1:0] != 2'd0;
         default: return a != 3'd0;
      endcase
   endfunction

   function automatic logic [63:0] extract(input logic [63:0] d, input logic [1:0] sz,
                                           input logic [2:0] lane, input logic uns);
      logic [63:0] f;
      f = d >> {lane, 3'b000};
      case (sz)
         2'd0:    return uns ? {56'd0, f[7:0]}  : {{56{f[7]}},  f[7:0]};
         2'd1:    return uns ? {48'd0, f[15:0]} : {{48{f[15]}}, f[15:0]};
         2'd2:    return uns ? {32'd0, f[31:0]} : {{32{f[31]}}, f[31:0]};
         default: return f;
      endcase
   endfunction

   // Replace only the byte lanes covered by the store; other lanes keep the read value.
   function automatic logic [63:0] merge(input logic [63:0] rbuf, input logic [63:0] wd,
                                         input logic [1:0] sz, input logic [2:0] lane);
      logic [63:0] sh;
      logic [7:0]  m;
      logic [63:0] r;
      sh = wd << {lane, 3'b000};
      case (sz)
         2'd0:    m = 8'h01;
         2'd1:    m = 8'h03;
         2'd2:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      m = m << lane;
      for (int i = 0; i < 8; i++) begin
         r[8*i +: 8] = m[i] ? sh[8*i +: 8] : rbuf[8*i +: 8];
      end
      return r;
   endfunction

   assign req_mis_d = misaligned(bus.req_size, bus.req_addr[2:0]);
   assign ld_data_d = extract(bus.mem_rdata, lat_size_q, lat_addr_q[2:0], lat_uns_q);
   assign merge_d   = merge(rd_buf_q, lat_wdata_q, lat_size_q, lat_addr_q[2:0]);

   // Strobes decode from state alone so reset kills a pending write immediately.
   assign bus.req_ready    = (state_q == IDLE);
   assign bus.rsp_valid    = (state_q == RESP);
   assign bus.mem_wr       = (state_q == WRITE);
   assign bus.mem_addr     = {lat_addr_q[63:3], 3'b000};
   assign bus.mem_wdata    = merge_d;
   assign bus.rsp_rdata    = rsp_rdata_q;
   assign bus.rsp_misalign = rsp_mis_q;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         lat_we_q    <= 1'b0;
         lat_uns_q   <= 1'b0;
         lat_size_q  <= 2'd0;
         lat_addr_q  <= 64'd0;
         lat_wdata_q <= 64'd0;
         rd_buf_q    <= 64'd0;
         rsp_rdata_q <= 64'd0;
         rsp_mis_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  lat_we_q    <= bus.req_we;
                  lat_uns_q   <= bus.req_unsigned;
                  lat_size_q  <= bus.req_size;
                  lat_addr_q  <= bus.req_addr;
                  lat_wdata_q <= bus.req_wdata;
                  if (req_mis_d) begin
                     rsp_rdata_q <= 64'd0;
                     rsp_mis_q   <= 1'b1;
                     state_q     <= RESP;
                  end else if (bus.req_we && bus.req_size == 2'd3) begin
                     state_q <= WRITE;
                  end else begin
                     cnt_q   <= CNT_W'(WAIT_CYCLES);
                     state_q <= READ;
                  end
               end
            end
            READ: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  rd_buf_q <= bus.mem_rdata;
                  if (lat_we_q) begin
                     state_q <= WRITE;
                  end else begin
                     rsp_rdata_q <= ld_data_d;
                     rsp_mis_q   <= 1'b0;
                     state_q     <= RESP;
                  end
               end
            end
            WRITE: begin
               rsp_rdata_q <= 64'd0;
               rsp_mis_q   <= 1'b0;
               state_q     <= RESP;
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   a_wait_cycles: assert property (@(posedge Clk) WAIT_CYCLES >= 1);

endmodule
